// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the FIFO write-port arbiter: FSM encoding and
// width/slice helpers used by the top and the round-robin picker.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Index width for NUM_REQ requesters, never narrower than one bit.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // LSB of requester idx inside a packed word bus.
  function automatic int slice_lsb(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first valid index at or after rr_ptr,
// wrapping modulo NUM_REQ (NUM_REQ need not be a power of two).
module rr_picker
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int GW = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [GW-1:0]      rr_ptr,
  output logic [GW-1:0]      pick,
  output logic               any_valid
);

  localparam int SW = GW + 1;

  logic [NUM_REQ-1:0] rot;
  logic [SW-1:0]      sum;

  // Rotate so bit k means requester (rr_ptr + k) mod NUM_REQ; scan high to low
  // so the smallest offset wins.
  always_comb begin
    rot       = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    pick      = '0;
    any_valid = 1'b0;
    sum       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        sum = {1'b0, rr_ptr} + SW'(k);
        if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
        pick      = sum[GW-1:0];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one FIFO write port among
// NUM_REQ producers; never writes while the FIFO reports full.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int GW = grant_w(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_data,
  output logic [GW-1:0]                 grant_id,
  output logic                          busy
);

  localparam int BW = $clog2(MAX_BURST) + 1;

  arb_state_e    state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] owner_q, owner_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;

  logic          grant, owner_valid, transfer, rel_grant, any_valid;
  logic [GW-1:0] pick;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .pick      (pick),
    .any_valid (any_valid)
  );

  assign grant = (state_q == ST_GRANT);

  // Owner-side muxing; ready and data depend only on registered state and full.
  always_comb begin
    owner_valid = 1'b0;
    req_ready   = '0;
    fifo_data   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == GW'(i)) begin
        owner_valid  = req_valid[i];
        req_ready[i] = grant && !fifo_full;
        if (grant) fifo_data = req_data[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  assign transfer = grant && !fifo_full && owner_valid;
  assign fifo_wr  = transfer;
  assign grant_id = owner_q;
  assign busy     = grant;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    rel_grant   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          owner_d     = pick;
          burst_cnt_d = '0;
          state_d     = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A dropped valid ends the burst even while the FIFO is full.
        if (!owner_valid) begin
          rel_grant = 1'b1;
        end else if (transfer) begin
          if (burst_cnt_q == BW'(MAX_BURST - 1)) rel_grant = 1'b1;
          else burst_cnt_d = burst_cnt_q + 1'b1;
        end
        if (rel_grant) begin
          state_d     = ST_IDLE;
          burst_cnt_d = '0;
          rr_ptr_d    = (owner_q == GW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-requester word streams drive the
// DUTs, expected FIFO writes are queued and checked by a negedge monitor.
module tb_fifo_wr_arbiter;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] d;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;

  logic [3:0]  rv4;
  logic [31:0] rd4;
  logic [3:0]  rr4;
  logic        full4;
  logic        wr4;
  logic [7:0]  fd4;
  logic [1:0]  gid4;
  logic        busy4;

  logic [2:0]  rv3;
  logic [23:0] rd3;
  logic [2:0]  rr3;
  logic        full3;
  logic        wr3;
  logic [7:0]  fd3;
  logic [1:0]  gid3;
  logic        busy3;

  logic [7:0]  s4 [4][$];
  logic [7:0]  s3 [3][$];
  exp_t        q4 [$];
  exp_t        q3 [$];

  int checks = 0;
  int errors = 0;

  fifo_wr_arbiter dut4 (
    .clk (clk), .reset_n (reset_n), .req_valid (rv4), .req_data (rd4),
    .req_ready (rr4), .fifo_full (full4), .fifo_wr (wr4), .fifo_data (fd4),
    .grant_id (gid4), .busy (busy4)
  );

  fifo_wr_arbiter #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(4)) dut3 (
    .clk (clk), .reset_n (reset_n), .req_valid (rv3), .req_data (rd3),
    .req_ready (rr3), .fifo_full (full3), .fifo_wr (wr3), .fifo_data (fd3),
    .grant_id (gid3), .busy (busy3)
  );

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic ex4(input int id, input int d);
    exp_t e;
    e.id = id[1:0];
    e.d  = d[7:0];
    q4.push_back(e);
  endtask

  task automatic ex3(input int id, input int d);
    exp_t e;
    e.id = id[1:0];
    e.d  = d[7:0];
    q3.push_back(e);
  endtask

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      rv4[i]       = (s4[i].size() != 0);
      rd4[i*8 +: 8] = (s4[i].size() != 0) ? s4[i][0] : 8'h00;
    end
    for (int i = 0; i < 3; i++) begin
      rv3[i]       = (s3[i].size() != 0);
      rd3[i*8 +: 8] = (s3[i].size() != 0) ? s3[i][0] : 8'h00;
    end
  endtask

  task automatic clear_streams();
    for (int i = 0; i < 4; i++) s4[i].delete();
    for (int i = 0; i < 3; i++) s3[i].delete();
    apply();
  endtask

  // One clock: accepted words (ready & valid before the edge) leave their stream.
  task automatic run_cycle();
    logic [3:0] a4;
    logic [2:0] a3;
    @(negedge clk);
    a4 = rr4 & rv4;
    a3 = rr3 & rv3;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (a4[i]) s4[i].delete(0);
    for (int i = 0; i < 3; i++) if (a3[i]) s3[i].delete(0);
    apply();
  endtask

  function automatic bit streams_busy();
    bit b = 1'b0;
    for (int i = 0; i < 4; i++) if (s4[i].size() != 0) b = 1'b1;
    for (int i = 0; i < 3; i++) if (s3[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while (streams_busy() && n < budget) begin
      run_cycle();
      n++;
    end
    chk(!streams_busy(), "drain_budget", n, budget);
    run_cycle();
    run_cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    full4   = 1'b0;
    clear_streams();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    exp_t e;
    int   n;

    fork
      forever begin
        @(negedge clk);
        if (wr4) begin
          if (q4.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr4_unexpected actual id=%0d data=%h expected no write", gid4, fd4);
          end else begin
            e = q4.pop_front();
            chk(fd4 === e.d && gid4 === e.id && !full4, "wr4_word",
                int'({gid4, fd4}), int'({e.id, e.d}));
          end
        end
        if (wr3) begin
          if (q3.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL wr3_unexpected actual id=%0d data=%h expected no write", gid3, fd3);
          end else begin
            e = q3.pop_front();
            chk(fd3 === e.d && gid3 === e.id && !full3, "wr3_word",
                int'({gid3, fd3}), int'({e.id, e.d}));
          end
        end
      end
    join_none

    // Reset state with requests pending
    reset_n = 1'b0;
    full4   = 1'b0;
    full3   = 1'b0;
    clear_streams();
    rv4 = 4'hF;
    rd4 = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    chk(rr4 === 4'h0, "rst_ready", int'(rr4), 0);
    chk(wr4 === 1'b0, "rst_wr", int'(wr4), 0);
    chk(fd4 === 8'h00, "rst_data", int'(fd4), 0);
    chk(gid4 === 2'd0, "rst_grant_id", int'(gid4), 0);
    chk(busy4 === 1'b0, "rst_busy", int'(busy4), 0);
    apply();
    reset_n = 1'b1;
    run_cycle();

    // Single requester 2 streams three words
    s4[2] = '{8'h11, 8'h22, 8'h33};
    ex4(2, 8'h11); ex4(2, 8'h22); ex4(2, 8'h33);
    apply();
    run_cycle();
    chk(gid4 === 2'd2 && busy4 === 1'b1, "t1_grant", int'(gid4), 2);
    chk(rr4 === 4'b0100, "t1_ready", int'(rr4), 4);
    repeat (3) run_cycle();
    chk(busy4 === 1'b1 && rv4[2] === 1'b0, "t1_busy_hold", int'(busy4), 1);
    run_cycle();
    chk(busy4 === 1'b0, "t1_busy_drop", int'(busy4), 0);
    chk(q4.size() == 0, "t1_all_written", q4.size(), 0);

    // All four continuously valid: 8 grants of 4 words, one bubble each
    do_reset();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++) s4[i].push_back(8'(i * 16 + j));
    for (int g = 0; g < 8; g++)
      for (int w = 0; w < 4; w++) ex4(g % 4, (g % 4) * 16 + (g / 4) * 4 + w);
    apply();
    n = 0;
    while (streams_busy() && n < 100) begin
      run_cycle();
      n++;
    end
    chk(n == 40, "t2_cycles", n, 40);
    chk(q4.size() == 0, "t2_all_written", q4.size(), 0);

    // fifo_full for 3 cycles after two words of a burst from requester 1
    do_reset();
    s4[1] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    ex4(1, 8'hA1); ex4(1, 8'hA2); ex4(1, 8'hA3); ex4(1, 8'hA4);
    apply();
    repeat (3) run_cycle();
    full4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk(rr4 === 4'h0, "t3_ready_full", int'(rr4), 0);
      chk(wr4 === 1'b0, "t3_wr_full", int'(wr4), 0);
      chk(busy4 === 1'b1 && gid4 === 2'd1, "t3_grant_held", int'(gid4), 1);
      run_cycle();
    end
    full4 = 1'b0;
    run_cycle();
    run_cycle();
    chk(busy4 === 1'b0, "t3_burst_end", int'(busy4), 0);
    chk(q4.size() == 0 && s4[1].size() == 0, "t3_no_loss", q4.size(), 0);

    // NUM_REQ=3: rr_ptr at 2, requests from 0 and 2
    do_reset();
    s3[1] = '{8'h51};
    ex3(1, 8'h51);
    apply();
    repeat (3) run_cycle();
    s3[0] = '{8'h61};
    s3[2] = '{8'h71};
    ex3(2, 8'h71); ex3(0, 8'h61);
    apply();
    run_cycle();
    chk(gid3 === 2'd2 && busy3 === 1'b1, "t4_first_pick", int'(gid3), 2);
    repeat (3) run_cycle();
    chk(gid3 === 2'd0 && busy3 === 1'b1, "t4_wrap_pick", int'(gid3), 0);
    repeat (2) run_cycle();
    s3[0] = '{8'h62};
    s3[2] = '{8'h72};
    ex3(2, 8'h72); ex3(0, 8'h62);
    apply();
    drain(20);
    chk(q3.size() == 0, "t4_all_written", q3.size(), 0);

    // Async reset during burst word 2
    do_reset();
    s4[2] = '{8'hB1, 8'hB2, 8'hB3};
    ex4(2, 8'hB1);
    apply();
    run_cycle();
    run_cycle();
    #1;
    chk(wr4 === 1'b1, "t5_pre_wr", int'(wr4), 1);
    #1;
    reset_n = 1'b0;
    #1;
    chk(wr4 === 1'b0, "t5_wr_async", int'(wr4), 0);
    chk(rr4 === 4'h0, "t5_ready_async", int'(rr4), 0);
    chk(busy4 === 1'b0, "t5_busy_async", int'(busy4), 0);
    clear_streams();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    s4[0] = '{8'hC0};
    s4[3] = '{8'hC3};
    ex4(0, 8'hC0); ex4(3, 8'hC3);
    apply();
    run_cycle();
    chk(gid4 === 2'd0 && busy4 === 1'b1, "t5_restart_owner", int'(gid4), 0);
    drain(20);
    chk(q4.size() == 0, "t5_all_written", q4.size(), 0);

    // Starvation: requester 0 always valid, requester 3 pulses once
    do_reset();
    for (int k = 0; k < 12; k++) s4[0].push_back(8'(8'h80 + k));
    for (int k = 0; k < 4; k++) ex4(0, 8'h80 + k);
    ex4(3, 8'hD3);
    for (int k = 4; k < 12; k++) ex4(0, 8'h80 + k);
    apply();
    run_cycle();
    run_cycle();
    s4[3].push_back(8'hD3);
    apply();
    n = 0;
    while (!(busy4 === 1'b1 && gid4 === 2'd3) && n < 6) begin
      run_cycle();
      n++;
    end
    chk(busy4 === 1'b1 && gid4 === 2'd3, "t6_req3_granted", n, 4);
    drain(60);
    chk(q4.size() == 0, "t6_all_written", q4.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
